// File: rtl/regex_cmd_package.sv
// Shared opcodes, status codes and command-field positions for the regex
// coprocessor command front-end.
package regex_cmd_package;

  typedef enum logic [7:0] {
    CMD_NOP                = 8'd0,
    CMD_WRITE              = 8'd1,
    CMD_READ               = 8'd2,
    CMD_START              = 8'd3,
    CMD_RESET              = 8'd4,
    CMD_READ_ELAPSED_CLOCK = 8'd5
  } cmd_op_e;

  typedef enum logic [2:0] {
    STATUS_IDLE     = 3'd0,
    STATUS_RUNNING  = 3'd1,
    STATUS_ACCEPTED = 3'd2,
    STATUS_REJECTED = 3'd3,
    STATUS_ERROR    = 3'd4
  } status_e;

  localparam int CMD_OP_LSB = 0;
  localparam int CMD_OP_MSB = 7;
  localparam int CMD_CH_LSB = 8;
  localparam int CMD_CH_MSB = 15;
  localparam int STATUS_W   = 3;

endpackage

// File: rtl/regex_channel_fsm.sv
// One matching-core channel: status FSM, start/reset pulse generation and a
// saturating elapsed-cycle counter. state_o exposes the FSM state directly.
module regex_channel_fsm
  import regex_cmd_package::*;
#(
  parameter int CC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                reset_i,
  input  logic                done_i,
  input  logic                accept_i,
  input  logic                ptr_ok_i,
  output logic [2:0]          state_o,
  output logic [CC_WIDTH-1:0] count_o,
  output logic                start_pulse_o,
  output logic                rst_pulse_o
);

  status_e             state_q, state_d;
  logic [CC_WIDTH-1:0] count_q, count_d;
  logic                start_pulse_q, start_pulse_d;
  logic                rst_pulse_q, rst_pulse_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= STATUS_IDLE;
      count_q       <= '0;
      start_pulse_q <= 1'b0;
      rst_pulse_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      start_pulse_q <= start_pulse_d;
      rst_pulse_q   <= rst_pulse_d;
    end
  end

  // A reset command outranks a same-cycle core_done.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    start_pulse_d = 1'b0;
    rst_pulse_d   = 1'b0;
    if (reset_i) begin
      state_d     = STATUS_IDLE;
      count_d     = '0;
      rst_pulse_d = 1'b1;
    end else begin
      case (state_q)
        STATUS_IDLE, STATUS_ACCEPTED, STATUS_REJECTED: begin
          if (start_i) begin
            if (ptr_ok_i) begin
              state_d       = STATUS_RUNNING;
              count_d       = '0;
              start_pulse_d = 1'b1;
            end else begin
              state_d = STATUS_ERROR;
            end
          end
        end
        STATUS_RUNNING: begin
          if (done_i) begin
            state_d = accept_i ? STATUS_ACCEPTED : STATUS_REJECTED;
          end else if (count_q != '1) begin
            count_d = count_q + CC_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign state_o       = state_q;
  assign count_o       = count_q;
  assign start_pulse_o = start_pulse_q;
  assign rst_pulse_o   = rst_pulse_q;

endmodule

// File: rtl/regex_cmd_controller.sv
// Host command front-end: decodes the command registers into a shared BRAM
// port and N matching-core channels, and muxes status/data back to the host.
module regex_cmd_controller
  import regex_cmd_package::*;
#(
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int N_CHANNELS = 4,
  parameter int CC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_WIDTH-1:0]  cmd_register,
  input  logic [REG_WIDTH-1:0]  address_register,
  input  logic [REG_WIDTH-1:0]  data_in_register,
  input  logic [REG_WIDTH-1:0]  start_cc_pointer_register,
  input  logic [REG_WIDTH-1:0]  end_cc_pointer_register,
  output logic [REG_WIDTH-1:0]  status_register,
  output logic [REG_WIDTH-1:0]  data_o_register,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]  mem_wdata,
  input  logic [REG_WIDTH-1:0]  mem_rdata,
  output logic [N_CHANNELS-1:0] core_start,
  output logic [N_CHANNELS-1:0] core_rst,
  output logic [REG_WIDTH-1:0]  core_start_cc,
  output logic [REG_WIDTH-1:0]  core_end_cc,
  input  logic [N_CHANNELS-1:0] core_done,
  input  logic [N_CHANNELS-1:0] core_accept
);

  logic [7:0] cmd_op, cmd_ch;
  logic       unused_cmd_bits;
  logic       ch_valid, cmd_edge, addr_oob, ptr_ok;
  logic       start_edge, reset_edge, elapsed_edge, sel_startable;
  logic [2:0]          sel_state;
  logic [CC_WIDTH-1:0] sel_cnt;
  logic [2:0]          ch_state [N_CHANNELS];
  logic [CC_WIDTH-1:0] ch_count [N_CHANNELS];

  logic [7:0]            prev_cmd_q;
  logic                  mem_we_q, mem_we_d, mem_re_q, mem_re_d, rd_pend_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [REG_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic                  err_q, err_d;
  logic [REG_WIDTH-1:0]  status_q, status_d, data_o_q, data_o_d;
  logic [REG_WIDTH-1:0]  start_cc_q, start_cc_d, end_cc_q, end_cc_d;

  assign cmd_op          = cmd_register[CMD_OP_MSB:CMD_OP_LSB];
  assign cmd_ch          = cmd_register[CMD_CH_MSB:CMD_CH_LSB];
  assign unused_cmd_bits = ^cmd_register[REG_WIDTH-1:CMD_CH_MSB+1];
  assign ch_valid        = 32'(cmd_ch) < N_CHANNELS;
  assign cmd_edge        = cmd_op != prev_cmd_q;
  assign start_edge      = cmd_edge && (cmd_op == CMD_START);
  assign reset_edge      = cmd_edge && (cmd_op == CMD_RESET);
  assign elapsed_edge    = cmd_edge && (cmd_op == CMD_READ_ELAPSED_CLOCK);
  assign addr_oob        = |address_register[REG_WIDTH-1:ADDR_WIDTH];
  assign ptr_ok          = start_cc_pointer_register <= end_cc_pointer_register;

  for (genvar g = 0; g < N_CHANNELS; g++) begin : g_ch
    regex_channel_fsm #(.CC_WIDTH(CC_WIDTH)) u_fsm (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_edge && (cmd_ch == 8'(g))),
      .reset_i      (reset_edge && (cmd_ch == 8'(g))),
      .done_i       (core_done[g]),
      .accept_i     (core_accept[g]),
      .ptr_ok_i     (ptr_ok),
      .state_o      (ch_state[g]),
      .count_o      (ch_count[g]),
      .start_pulse_o(core_start[g]),
      .rst_pulse_o  (core_rst[g])
    );
  end

  // Channels outside the implemented range read back as ERROR.
  always_comb begin
    sel_state = STATUS_ERROR;
    sel_cnt   = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      if (cmd_ch == 8'(i)) begin
        sel_state = ch_state[i];
        sel_cnt   = ch_count[i];
      end
    end
  end

  assign sel_startable = (sel_state == STATUS_IDLE) || (sel_state == STATUS_ACCEPTED) ||
                         (sel_state == STATUS_REJECTED);

  always_comb begin
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    data_o_d    = data_o_q;
    start_cc_d  = start_cc_q;
    end_cc_d    = end_cc_q;
    status_d    = '0;
    if ((cmd_op == CMD_WRITE) || (cmd_op == CMD_READ)) begin
      if (addr_oob) begin
        err_d = 1'b1;
      end else begin
        mem_addr_d = address_register[ADDR_WIDTH-1:0];
        mem_we_d   = cmd_op == CMD_WRITE;
        mem_re_d   = cmd_op == CMD_READ;
        if (cmd_op == CMD_WRITE) mem_wdata_d = data_in_register;
      end
    end
    if ((start_edge || reset_edge || elapsed_edge) && !ch_valid) err_d = 1'b1;
    if (reset_edge && ch_valid) err_d = 1'b0;
    if (start_edge && ch_valid && ptr_ok && sel_startable) begin
      start_cc_d = start_cc_pointer_register;
      end_cc_d   = end_cc_pointer_register;
    end
    // A fresh elapsed-count request takes the data register over a trailing read.
    if (rd_pend_q) data_o_d = mem_rdata;
    if (elapsed_edge && ch_valid) data_o_d = REG_WIDTH'(sel_cnt);
    status_d[STATUS_W-1:0] = sel_state;
    status_d[REG_WIDTH-1]  = err_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_cmd_q  <= CMD_NOP;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
      status_q    <= '0;
      data_o_q    <= '0;
      start_cc_q  <= '0;
      end_cc_q    <= '0;
    end else begin
      prev_cmd_q  <= cmd_op;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      rd_pend_q   <= mem_re_q;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      status_q    <= status_d;
      data_o_q    <= data_o_d;
      start_cc_q  <= start_cc_d;
      end_cc_q    <= end_cc_d;
    end
  end

  assign mem_we          = mem_we_q;
  assign mem_re          = mem_re_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign status_register = status_q;
  assign data_o_register = data_o_q;
  assign core_start_cc   = start_cc_q;
  assign core_end_cc     = end_cc_q;

endmodule
